// File: rtl/duty_clk_ctrl_if.sv
//==============================================================================
// Module      : duty_clk_ctrl_if
// Description : Configuration handshake bundle for duty_clk_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface duty_clk_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [7:0]       cfg_duty;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready,
        output cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/duty_clk_ctrl.sv
//==============================================================================
// Module      : duty_clk_ctrl
// Description : Programmable period / 8-bit duty divided-clock generator.
//               DUTY_CLK_CTRL_GLITCHFREE_EN: defer new configurations to
//               IDLE or the period boundary (otherwise apply immediately).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module duty_clk_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire            clk,
    input  wire            rst,
    input  wire            en,
    duty_clk_ctrl_if.slave cfg,
    output logic           clk_out,
    output logic           period_done,
    output logic           running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_two = CNT_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_start_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_start_cnt;
    logic [CNT_W-1:0] r_sh_ton;
    logic [CNT_W-1:0] r_sh_toff;
    logic [CNT_W-1:0] r_act_ton;
    logic [CNT_W-1:0] r_act_toff;
    logic [CNT_W-1:0] w_ton;
    logic [CNT_W-1:0] w_toff;
    logic [CNT_W-1:0] w_new_ton;
    logic [CNT_W+7:0] w_prod;
    logic             r_pending;
    logic             r_act_valid;
    logic             r_clk_out;
    logic             r_cfg_err;
    logic             w_hs;
    logic             w_illegal;
    logic             w_apply;
    logic             w_boundary;

    assign w_hs       = cfg.cfg_valid && !r_pending;
    assign w_illegal  = cfg.cfg_period < c_two;
    assign w_prod     = {8'd0, cfg.cfg_period} * {{CNT_W{1'b0}}, cfg.cfg_duty};
    assign w_new_ton  = CNT_W'(w_prod >> 8);
    assign w_boundary = (r_state == S_LOW) && (r_cnt == '0);

`ifdef DUTY_CLK_CTRL_GLITCHFREE_EN
    assign w_apply = r_pending && ((r_state == S_IDLE) || w_boundary);
`else
    assign w_apply = r_pending;
`endif

    // Values that the next period starts from, including a shadow applied this edge
    assign w_ton  = w_apply ? r_sh_ton  : r_act_ton;
    assign w_toff = w_apply ? r_sh_toff : r_act_toff;

    always_comb begin
        w_start_state = S_HIGH;
        w_start_cnt   = w_ton - c_one;
        if (w_ton == '0) begin
            w_start_state = S_LOW;
            w_start_cnt   = w_toff - c_one;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (en && r_act_valid && !r_pending) begin
                    w_state_nxt = w_start_state;
                    w_cnt_nxt   = w_start_cnt;
                end
            end
            S_HIGH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = r_act_toff - c_one;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            S_LOW: begin
                if (w_boundary) begin
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = w_start_state;
                        w_cnt_nxt   = w_start_cnt;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifndef DUTY_CLK_CTRL_GLITCHFREE_EN
        // Immediate reconfiguration abandons the running period
        if (r_pending && (r_state != S_IDLE)) begin
            w_state_nxt = w_start_state;
            w_cnt_nxt   = w_start_cnt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sh_ton    <= '0;
            r_sh_toff   <= '0;
            r_act_ton   <= '0;
            r_act_toff  <= '0;
            r_pending   <= 1'b0;
            r_act_valid <= 1'b0;
            r_clk_out   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= (w_state_nxt == S_HIGH);
            r_cfg_err <= w_hs && w_illegal;
            if (w_apply) begin
                r_act_ton   <= r_sh_ton;
                r_act_toff  <= r_sh_toff;
                r_act_valid <= 1'b1;
                r_pending   <= 1'b0;
            end else if (w_hs && !w_illegal) begin
                r_sh_ton  <= w_new_ton;
                r_sh_toff <= cfg.cfg_period - w_new_ton;
                r_pending <= 1'b1;
            end
        end
    end

    assign clk_out       = r_clk_out;
    assign period_done   = w_boundary;
    assign running       = (r_state != S_IDLE);
    assign cfg.cfg_ready = !r_pending;
    assign cfg.cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_duty_clk_ctrl.sv
//==============================================================================
// Module      : tb_duty_clk_ctrl
// Description : Self-checking bench for duty_clk_ctrl; expected per-cycle
//               output vectors are queued up front and popped each cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_duty_clk_ctrl;

    logic clk;
    logic rst;
    logic en;
    logic clk_out;
    logic period_done;
    logic running;

    duty_clk_ctrl_if #(.CNT_W(16)) cfg_if ();

    duty_clk_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg         (cfg_if),
        .clk_out     (clk_out),
        .period_done (period_done),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Vector layout: {clk_out, period_done, running, cfg_ready, cfg_err}
    logic [4:0] sb[$];

    function automatic void push_v(input logic [4:0] v);
        sb.push_back(v);
    endfunction

    function automatic void push_start();
        push_v(5'b00000);
        push_v(5'b00010);
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) push_v(5'b00010);
    endfunction

    function automatic void push_period(input int ton, input int toff);
        for (int k = 0; k < ton; k++) push_v(5'b10110);
        for (int k = 0; k < toff; k++) push_v((k == toff - 1) ? 5'b01110 : 5'b00110);
    endfunction

    function automatic void clr_rdy(input int a, input int b);
        for (int k = a; k <= b; k++) sb[k] = sb[k] & 5'b11101;
    endfunction

    function automatic logic [4:0] observed();
        return {clk_out, period_done, running, cfg_if.cfg_ready, cfg_if.cfg_err};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [4:0] o, e;
        do_reset();
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
        total++; if (period_done !== 1'b0) begin bad++; $display("FAIL reset_period_done got=%b exp=0", period_done); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_if.cfg_ready); end
        total++; if (cfg_if.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_if.cfg_err); end
        // en without any configuration must stay idle
        push_idle(4);
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, o, e); end
        end
    endtask

    task automatic test_basic();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        push_period(20, 20);
        push_period(20, 20);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cfg_if.cfg_valid  = (i == 0);
            cfg_if.cfg_period = 16'd40;
            cfg_if.cfg_duty   = 8'd128;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_reconfig();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        push_period(2, 8);
`ifdef DUTY_CLK_CTRL_GLITCHFREE_EN
        push_period(2, 8);
        clr_rdy(13, 21);
        push_period(6, 2);
        push_period(6, 2);
`else
        push_v(5'b10110);
        push_v(5'b10100);
        push_period(6, 2);
        push_period(6, 2);
        push_period(6, 2);
`endif
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cfg_if.cfg_valid = (i == 0) || (i == 13);
            cfg_if.cfg_period = (i == 0) ? 16'd10 : 16'd8;
            cfg_if.cfg_duty   = (i == 0) ? 8'd64  : 8'd192;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL reconfig cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_zero_duty_err();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        for (int k = 0; k < 4; k++) push_period(0, 5);
        sb[12] = sb[12] | 5'b00001;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cfg_if.cfg_valid  = (i == 0) || (i == 12);
            cfg_if.cfg_period = (i == 0) ? 16'd5 : 16'd1;
            cfg_if.cfg_duty   = 8'd0;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL zero_duty_err cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_enable_stop();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        push_period(20, 20);
        push_idle(4);
        push_period(20, 20);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = !((i >= 5) && (i <= 45));
            cfg_if.cfg_valid  = (i == 0);
            cfg_if.cfg_period = 16'd40;
            cfg_if.cfg_duty   = 8'd128;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL enable_stop cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_rst_mid_low();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        for (int k = 0; k < 5; k++) push_v(5'b10110);
        push_v(5'b00110);
        push_v(5'b00110);
        push_idle(11);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en  = 1'b1;
            rst = (i == 9);
            cfg_if.cfg_valid  = (i == 0);
            cfg_if.cfg_period = 16'd10;
            cfg_if.cfg_duty   = 8'd128;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL rst_mid_low cyc=%0d got=%b exp=%b", i, o, e); end
        end
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
    endtask

`ifdef DUTY_CLK_CTRL_GLITCHFREE_EN
    task automatic test_boundary_cfg();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        push_period(3, 3);
        push_period(3, 3);
        clr_rdy(8, 13);
        push_period(2, 6);
        push_period(2, 6);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cfg_if.cfg_valid  = (i == 0) || (i == 8);
            cfg_if.cfg_period = (i == 0) ? 16'd6 : 16'd8;
            cfg_if.cfg_duty   = (i == 0) ? 8'd128 : 8'd64;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL boundary_cfg cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask
`else
    task automatic test_abort_reload();
        logic [4:0] o, e;
        int n;
        do_reset();
        push_start();
        for (int k = 0; k < 3; k++) push_v(5'b10110);
        push_v(5'b10100);
        for (int k = 0; k < 3; k++) push_period(3, 3);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cfg_if.cfg_valid  = (i == 0) || (i == 5);
            cfg_if.cfg_period = (i == 0) ? 16'd40 : 16'd6;
            cfg_if.cfg_duty   = 8'd128;
            @(posedge clk); #1;
            o = observed(); e = sb.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL abort_reload cyc=%0d got=%b exp=%b", i, o, e); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        test_reset();
        test_basic();
        test_reconfig();
        test_zero_duty_err();
        test_enable_stop();
        test_rst_mid_low();
`ifdef DUTY_CLK_CTRL_GLITCHFREE_EN
        test_boundary_cfg();
`else
        test_abort_reload();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
